fb_readback_port: RTL
=====================

Name: fb_readback_port

Overview:
- Shares the single read port of the VGA index framebuffer between two clients: display scanout and processor load data.
- Scanout always has priority.
- A processor read waits until a cycle with no scanout request, then is issued to the memory; the returned index is zero-extended onto the processor's `memory_read_data` path.
- Sits between the processor, the vga_controller scan logic and the framebuffer RAM read port.

Parameters:
- ADDR_W, 19, framebuffer word address width (640x480 indices)
- IDX_W, 8, width of one stored colour index
- MEM_LAT, 2, fixed RAM read latency in cycles (address to data), range 1..4
- TIMEOUT, 1023, maximum cycles a processor read may wait for a free slot before being aborted

Ports:
- clock  in  1  single clock (VGA_CTRL_CLK domain)
- reset  in  1  asynchronous, active-high reset
- cpu_rd_req  in  1  one-cycle pulse: start processor read
- cpu_rd_addr  in  ADDR_W  processor read address, sampled with cpu_rd_req
- cpu_rd_data  out  32  {zeros, index}; 0 on timeout
- cpu_rd_valid  out  1  one-cycle pulse: cpu_rd_data valid
- cpu_rd_err  out  1  high with cpu_rd_valid when the read timed out
- cpu_busy  out  1  processor read pending or in flight
- scan_req  in  1  scanout read request this cycle
- scan_addr  in  ADDR_W  scanout address
- scan_data  out  IDX_W  scanout returned index
- scan_valid  out  1  scan_data valid
- mem_addr  out  ADDR_W  RAM read address
- mem_rd_data  in  IDX_W  RAM read data, MEM_LAT cycles after mem_addr

Behaviour:
- Reset values: all outputs 0; tag pipe cleared; state IDLE; wait counter 0.
- Reset asserted mid-operation discards the pending request and all in-flight reads. No valid pulse is emitted for them.
- Processor FSM states and transitions:
  - IDLE: on cpu_rd_req, latch cpu_rd_addr, clear the wait counter, go to PEND.
  - PEND: if scan_req=0, drive mem_addr=latched address, push tag CPU, go to FLIGHT. Otherwise increment the wait counter. If the counter reaches TIMEOUT while scan_req=1, pulse cpu_rd_valid with cpu_rd_err=1 and cpu_rd_data=0, then go to IDLE.
  - FLIGHT: when the CPU tag exits the pipe, pulse cpu_rd_valid with cpu_rd_data={32-IDX_W zeros, mem_rd_data}, go to IDLE.
- cpu_busy = (state != IDLE).
- cpu_rd_req while busy is ignored; it is neither queued nor errored.
- Slot selection each cycle:
  - scan_req=1: mem_addr=scan_addr, push tag SCAN, whatever the processor state.
  - else if PEND: processor issue as above.
  - else: mem_addr holds its last value, push tag NONE.
- Tag pipe: MEM_LAT stages of 2-bit owner tags. The output stage selects the destination:
  - SCAN: scan_valid=1, scan_data=mem_rd_data.
  - CPU: processor completion.
  - NONE: no pulse.
- Scan latency is exactly MEM_LAT cycles from scan_req to scan_valid. It is never disturbed by processor traffic.
- Best-case processor latency: cpu_rd_req at cycle 0, issue at cycle 1, cpu_rd_valid at cycle 1+MEM_LAT.
- The wait counter is clog2(TIMEOUT+1) bits, saturating, and is compared with ==.
- Simultaneous events in one cycle: a scan completion and the processor issue can coexist, as can a processor completion and a new scan issue. No collision is possible, because each pipe stage carries exactly one tag.

Decomposition:
- Package fb_readback_pkg holds:
  - typedef owner_t {OWN_NONE, OWN_SCAN, OWN_CPU}
  - typedef state_t {IDLE, PEND, FLIGHT}
  - constant CPU_DATA_W=32
- Sub-module fb_tag_pipe (parameter MEM_LAT): a shift register of owner_t with async reset to OWN_NONE and output tail tag.
- The top holds the FSM, wait counter and address mux.

Test Plan:
- No scan traffic, RAM preloaded addr 0x00123=0xA5, MEM_LAT=2: cpu_rd_req at cycle 0 -> cpu_rd_valid at cycle 3, cpu_rd_data=0x000000A5, err=0, cpu_busy high cycles 1-3.
- scan_req held high for addresses 0..9, cpu_rd_req at cycle 2 to 0x00050, scan_req drops at cycle 10:
  - scan_valid for all 10 reads at cycles 2..11 with correct data.
  - CPU issued at cycle 10, cpu_rd_valid at cycle 12.
- TIMEOUT=15, scan_req stuck high, cpu_rd_req at cycle 0 -> cpu_rd_valid and cpu_rd_err at the cycle the counter hits 15; data 0; next cycle cpu_busy=0.
- Second cpu_rd_req (addr 0x00200) during FLIGHT of the first (addr 0x00100) -> only one valid pulse, carrying the 0x00100 data; mem_addr never shows 0x00200.
- reset pulsed while the CPU tag is in the pipe, with 2 scan reads in flight -> no scan_valid or cpu_rd_valid afterwards; all outputs 0; a fresh read after reset completes normally.
- Alternating scan_req 1/0 every cycle with a CPU read pending -> the CPU issues in the first 0 cycle; scan_valid pattern equals scan_req delayed by exactly MEM_LAT.

Source files
------------

// File: rtl/fb_readback_pkg.sv
// Shared types and constants for the framebuffer read-port arbiter.
package fb_readback_pkg;

    // Width of the processor load-data path.
    localparam int CPU_DATA_W = 32;

    // Which client owns a read slot travelling through the RAM latency.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SCAN = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    // Processor read life cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        FLIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/fb_readback_port_tag_pipe.sv
// Owner-tag delay line matching the RAM read latency. Each RAM slot issued
// carries exactly one tag, and the tail tag names the owner of the data now
// arriving on the RAM read port.
module fb_tag_pipe
    import fb_readback_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  owner_t i_tag,
    output owner_t o_tail
);

    owner_t r_stage [MEM_LAT];

    // Shift the slot owner along in lock step with the RAM read pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_stage[i] <= OWN_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tail = r_stage[MEM_LAT-1];

endmodule

// File: rtl/fb_readback_port.sv
// Arbitrates the framebuffer's single read port between display scanout
// (always first) and processor loads. A processor read waits for a cycle
// without a scanout request, then rides the RAM latency with an owner tag
// so the returned index is steered to the right client.
module fb_readback_port
    import fb_readback_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int IDX_W   = 8,
    parameter int MEM_LAT = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_rd_req,
    input  logic [ADDR_W-1:0]     cpu_rd_addr,
    output logic [CPU_DATA_W-1:0] cpu_rd_data,
    output logic                  cpu_rd_valid,
    output logic                  cpu_rd_err,
    output logic                  cpu_busy,
    input  logic                  scan_req,
    input  logic [ADDR_W-1:0]     scan_addr,
    output logic [IDX_W-1:0]      scan_data,
    output logic                  scan_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [IDX_W-1:0]      mem_rd_data
);

    localparam int              CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    // Wait counter never passes the timeout value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == TIMEOUT_CNT) ? v : v + 1'b1;
    endfunction

    // Colour index placed in the low bits of the processor data word.
    function automatic logic [CPU_DATA_W-1:0] zext_idx(input logic [IDX_W-1:0] v);
        return {{(CPU_DATA_W-IDX_W){1'b0}}, v};
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [ADDR_W-1:0] r_last_addr;

    state_t            w_next_state;
    logic [CNT_W-1:0]  w_wait_next;
    logic              w_accept;
    logic              w_timeout;
    logic              w_cpu_done;
    owner_t            w_push_tag;
    owner_t            w_tail;
    logic [ADDR_W-1:0] w_mem_addr;

    // Processor FSM: accept, wait for a free slot (or give up), then await data.
    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_rd_req) begin
                    w_accept     = 1'b1;
                    w_next_state = PEND;
                    w_wait_next  = '0;
                end
            end
            PEND: begin
                if (!scan_req) begin
                    w_next_state = FLIGHT;
                end else if (r_wait == TIMEOUT_CNT) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_wait_next  = sat_inc(r_wait);
                end
            end
            FLIGHT: begin
                if (w_tail == OWN_CPU) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Slot selection: scanout wins every cycle it asks; an idle slot keeps
    // the previous address so the RAM input does not toggle needlessly.
    always_comb begin
        w_mem_addr = r_last_addr;
        w_push_tag = OWN_NONE;
        if (scan_req) begin
            w_mem_addr = scan_addr;
            w_push_tag = OWN_SCAN;
        end else if (r_state == PEND) begin
            w_mem_addr = r_cpu_addr;
            w_push_tag = OWN_CPU;
        end
    end

    // Control state, wait counter and held RAM address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_last_addr <= '0;
        end else begin
            r_state     <= w_next_state;
            r_wait      <= w_wait_next;
            r_last_addr <= w_mem_addr;
        end
    end

    // Processor address captured only when a request is accepted.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_cpu_addr <= cpu_rd_addr;
        end
    end

    fb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .i_tag  (w_push_tag),
        .o_tail (w_tail)
    );

    // Only the CPU read that is actually in flight can claim a CPU tag.
    assign w_cpu_done = (r_state == FLIGHT) && (w_tail == OWN_CPU);

    assign mem_addr     = w_mem_addr;
    assign scan_valid   = (w_tail == OWN_SCAN);
    assign scan_data    = scan_valid ? mem_rd_data : '0;
    assign cpu_rd_valid = w_cpu_done | w_timeout;
    assign cpu_rd_err   = w_timeout;
    assign cpu_rd_data  = w_cpu_done ? zext_idx(mem_rd_data) : '0;
    assign cpu_busy     = (r_state != IDLE);

endmodule
